// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares one memory-mapped master port
// between the buffered camera write stream and display read requests.
module fb_port_arbiter #(
  parameter logic [31:0] WR_BASE     = 32'h0000_0000,
  parameter logic [31:0] RD_BASE     = 32'h0000_0000,
  parameter int          FRAME_BYTES = 307200,
  parameter int          WFIFO_DEPTH = 4
) (
  input  logic        ctrl_clk,
  input  logic        reset,
  input  logic [31:0] iData,
  input  logic        iValid,
  input  logic        read_init,
  output logic [31:0] oData,
  output logic        oValid,
  output logic        wr_overflow,
  output logic        wr_frame_done,
  output logic        rd_frame_done,
  output logic        busy,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam logic [31:0] FB = 32'(FRAME_BYTES);
  localparam logic [31:0] WR_LAST = WR_BASE + FB - 32'd4;
  localparam logic [31:0] RD_LAST = RD_BASE + FB - 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t      r_state;
  logic [31:0] r_fifo [WFIFO_DEPTH];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic        r_rd_pend;
  logic        r_last_wr;
  logic [31:0] r_waddr;
  logic [31:0] r_raddr;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_grant_w;
  logic        w_grant_r;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = iValid && !w_full;

  // Write wins a tie only when the previous grant went to the read side
  assign w_grant_w = (r_state == S_IDLE) && !w_empty &&
                     (!r_rd_pend || !r_last_wr);
  assign w_grant_r = (r_state == S_IDLE) && r_rd_pend && !w_grant_w;

  // FIFO storage; contents need no reset, pointers define validity
  always_ff @(posedge ctrl_clk) begin
    if (w_push) r_fifo[r_wp[AW-1:0]] <= iData;
  end

  // FIFO pointers: push and pop may coincide
  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push)    r_wp <= r_wp + 1'b1;
      if (w_grant_w) r_rp <= r_rp + 1'b1;
    end
  end

  // Sticky overflow flag for words arriving at a full FIFO
  always_ff @(posedge ctrl_clk) begin
    if (reset)              wr_overflow <= 1'b0;
    else if (iValid && w_full) wr_overflow <= 1'b1;
  end

  // Single outstanding read request; extra requests are not queued
  always_ff @(posedge ctrl_clk) begin
    if (reset)          r_rd_pend <= 1'b0;
    else if (w_grant_r) r_rd_pend <= 1'b0;
    else if (read_init) r_rd_pend <= 1'b1;
  end

  // Port FSM with registered command, status and frame addresses
  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_wr     <= 1'b0;
      r_waddr       <= WR_BASE;
      r_raddr       <= RD_BASE;
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      busy          <= 1'b0;
      oData         <= '0;
      oValid        <= 1'b0;
      wr_frame_done <= 1'b0;
      rd_frame_done <= 1'b0;
    end else begin
      oValid        <= 1'b0;
      wr_frame_done <= 1'b0;
      rd_frame_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_w) begin
            avm_address   <= r_waddr;
            avm_writedata <= r_fifo[r_rp[AW-1:0]];
            avm_write     <= 1'b1;
            busy          <= 1'b1;
            r_last_wr     <= 1'b1;
            r_state       <= S_WRITE;
          end else if (w_grant_r) begin
            avm_address <= r_raddr;
            avm_read    <= 1'b1;
            busy        <= 1'b1;
            r_last_wr   <= 1'b0;
            r_state     <= S_READ;
          end
        end
        S_WRITE: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
            if (r_waddr == WR_LAST) begin
              r_waddr       <= WR_BASE;
              wr_frame_done <= 1'b1;
            end else begin
              r_waddr <= r_waddr + 32'd4;
            end
          end
        end
        S_READ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            busy     <= 1'b0;
            oData    <= avm_readdata;
            oValid   <= 1'b1;
            r_state  <= S_IDLE;
            if (r_raddr == RD_LAST) begin
              r_raddr       <= RD_BASE;
              rd_frame_done <= 1'b1;
            end else begin
              r_raddr <= r_raddr + 32'd4;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Single-clock scheduler that shares one 32-bit memory-mapped master port (address / read / write / waitrequest) between the camera write stream and the display read requester of the frame-buffer path. Buffers incoming write words in a small FIFO, generates wrapping frame addresses for both sides, and grants the port round-robin one transaction at a time. Sits between the capture/display logic and the bus system that owns the memory.

## Interface
- WR_BASE, 32'h0000_0000: byte address of the first write word in a frame
- RD_BASE, 32'h0000_0000: byte address of the first read word in a frame
- FRAME_BYTES, 307200: frame size in bytes; multiple of 4, at least 4
- WFIFO_DEPTH, 4: write FIFO entries; power of 2, at least 2

- ctrl_clk  in  1  sole clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- iData  in  32  write stream data
- iValid  in  1  iData valid this cycle; no back pressure
- read_init  in  1  request one word read at the next read address
- oData  out  32  read data; held between reads
- oValid  out  1  one-cycle pulse with oData
- wr_overflow  out  1  sticky: a write word was dropped
- wr_frame_done  out  1  one-cycle pulse on completion of the last write word of a frame
- rd_frame_done  out  1  one-cycle pulse on completion of the last read word of a frame
- busy  out  1  high in WRITE or READ
- avm_address  out  32  byte address
- avm_write  out  1  write command
- avm_writedata  out  32  write data
- avm_read  out  1  read command
- avm_readdata  in  32  read data; valid in the cycle the read completes
- avm_waitrequest  in  1  command stalled while high

## Operation
- Reset values: every output 0; avm_address 0; write address = WR_BASE; read address = RD_BASE; FIFO empty; read pending 0; last grant = READ, so WRITE wins the first tie; state IDLE.
- Write FIFO: push when iValid && !full, and a push is allowed in the same cycle as a pop. iValid while full drops the word and sets wr_overflow, which clears only on reset.
- Read request: read_init sets rd_pend. A read_init while rd_pend is already set is ignored and is not queued.
- States: IDLE, WRITE, READ.
- IDLE:
  - Candidates are FIFO not empty and rd_pend.
  - If both are present, grant the side not granted last.
  - Write grant: load avm_address = write address, avm_writedata = FIFO head, avm_write = 1, pop the FIFO, go to WRITE.
  - Read grant: load avm_address = read address, avm_read = 1, clear rd_pend, go to READ.
  - Record the grant in last_grant.
- WRITE: hold address, data and avm_write while avm_waitrequest = 1. On a cycle with avm_waitrequest = 0 the write completes:
  - deassert avm_write next cycle
  - advance the write address
  - return to IDLE
- READ: hold while avm_waitrequest = 1. On completion:
  - register oData = avm_readdata and pulse oValid
  - deassert avm_read
  - advance the read address
  - return to IDLE
- Address advance: +4. If the completed address equals BASE + FRAME_BYTES − 4, reload BASE and pulse the matching frame_done in the cycle after completion.
- avm_write and avm_read are never both high.

## Timing
- All outputs are registered.
- Grant: a request visible in IDLE at edge N gives avm_write or avm_read high after edge N.
- Completion: with waitrequest low in the first command cycle, the command lasts exactly 1 cycle.
- Read latency: oValid rises one cycle after the completion cycle; a read_init-to-oValid minimum of 3 cycles from an idle port.
- Back-to-back: there is one mandatory IDLE cycle between transactions, so peak port use is 1 transaction per 2 cycles.
- Steady state: iValid at 1/2 rate or less with waitrequest always low never overflows.
- Reset asserted mid-transaction drops the command next cycle. FIFO contents, rd_pend and the addresses are lost, and all outputs return to reset values.

## Test plan
- Parameters for all scenarios: FRAME_BYTES = 16, WR_BASE = 0x100, RD_BASE = 0x200, avm_waitrequest = 0 unless stated.
- Single write: iValid with iData = 0xA5A5_0001 → one-cycle avm_write at 0x100 with that data. The next word goes to 0x104.
- Wrap: 5 writes spaced 4 cycles apart → addresses 0x100, 0x104, 0x108, 0x10C, 0x100. wr_frame_done pulses exactly once, after the 0x10C write.
- Read with stall: read_init with waitrequest high for 3 cycles and avm_readdata = 0xDEAD_BEEF → avm_read high for 4 cycles at 0x200, then oValid for 1 cycle with oData = 0xDEAD_BEEF.
- Arbitration tie: FIFO non-empty and rd_pend set together from reset → WRITE granted first, then READ, alternating while both sides stay pending.
- Overflow: waitrequest held high, 6 consecutive iValid words → the first write is stuck, 4 words sit in the FIFO, and 1 word is dropped. wr_overflow stays 1 after waitrequest releases.
- Reset mid-read: reset asserted during a stalled READ → avm_read = 0 next cycle, oValid never pulses, and the next read after reset goes to 0x200.
